// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard: 1 write, 2 async reads, r0 hardwired to zero.
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic              ctrl_markBusy,
  input  logic [ADDR_W-1:0] ctrl_busyReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  output logic              busy_A,
  output logic              busy_B,
  output logic [ADDR_W-1:0] busy_count
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic             wr_hit, mk_hit;

  assign wr_hit = ctrl_writeEnable && (ctrl_writeReg != '0);
  assign mk_hit = ctrl_markBusy && (ctrl_busyReg != '0);

  // Mark is applied after the write clear so a new producer supersedes the old one.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit) busy_nxt[ctrl_writeReg] = 1'b0;
    if (mk_hit) busy_nxt[ctrl_busyReg] = 1'b1;
  end

  function automatic logic [ADDR_W-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [ADDR_W-1:0] n;
    n = '0;
    for (int i = 1; i < DEPTH; i++) n = n + ADDR_W'(v[i]);
    return n;
  endfunction

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_hit) mem[ctrl_writeReg] <= data_writeReg;
      busy       <= busy_nxt;
      busy_count <= popcnt(busy_nxt);
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_a, fwd_b;
  assign fwd_a = wr_hit && !ctrl_reset && (ctrl_writeReg == ctrl_readRegA);
  assign fwd_b = wr_hit && !ctrl_reset && (ctrl_writeReg == ctrl_readRegB);
`endif

  always_comb begin
    data_readRegA = (ctrl_readRegA == '0) ? '0 : mem[ctrl_readRegA];
    data_readRegB = (ctrl_readRegB == '0) ? '0 : mem[ctrl_readRegB];
    busy_A        = busy[ctrl_readRegA];
    busy_B        = busy[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    // Forwarded data is about to retire its producer, so busy drops unless re-marked.
    if (fwd_a) begin
      data_readRegA = data_writeReg;
      busy_A        = mk_hit && (ctrl_busyReg == ctrl_readRegA);
    end
    if (fwd_b) begin
      data_readRegB = data_writeReg;
      busy_B        = mk_hit && (ctrl_busyReg == ctrl_readRegB);
    end
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic vs. an array model.
module tb_regfile_sb;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 2**AW;

  logic          clock, ctrl_reset;
  logic          ctrl_writeEnable, ctrl_markBusy;
  logic [AW-1:0] ctrl_writeReg, ctrl_busyReg, ctrl_readRegA, ctrl_readRegB;
  logic [W-1:0]  data_writeReg, data_readRegA, data_readRegB;
  logic          busy_A, busy_B;
  logic [AW-1:0] busy_count;

  regfile_sb #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_markBusy(ctrl_markBusy), .ctrl_busyReg(ctrl_busyReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .busy_A(busy_A), .busy_B(busy_B), .busy_count(busy_count)
  );

  typedef struct {
    logic [W-1:0]  a, b;
    logic          ba, bb;
    logic [AW-1:0] cnt;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_reg [N];
  bit           m_busy [N];
  int           nvec = 0;
  int           nerr = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // One cycle: commit the previous inputs into the model at the edge, then drive new ones.
  task automatic step(input bit we, input int wa, input logic [W-1:0] wd,
                      input bit mb, input int ba, input int ra, input int rb, input bit rst);
    exp_t e;
    @(posedge clock);
    if (!ctrl_reset) begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_reg[ctrl_writeReg]  = data_writeReg;
        m_busy[ctrl_writeReg] = 0;
      end
      if (ctrl_markBusy && ctrl_busyReg != 0) m_busy[ctrl_busyReg] = 1;
    end
    #1;
    ctrl_writeEnable = we; ctrl_writeReg = AW'(wa); data_writeReg = wd;
    ctrl_markBusy = mb; ctrl_busyReg = AW'(ba);
    ctrl_readRegA = AW'(ra); ctrl_readRegB = AW'(rb);
    ctrl_reset = rst;
    if (rst) model_clear();
    e.a   = (ra == 0) ? '0 : m_reg[ra];
    e.b   = (rb == 0) ? '0 : m_reg[rb];
    e.ba  = m_busy[ra];
    e.bb  = m_busy[rb];
    e.cnt = AW'(model_count());
`ifdef REGFILE_BYPASS_EN
    if (!rst && we && wa != 0 && wa == ra) begin e.a = wd; e.ba = mb && (ba == ra); end
    if (!rst && we && wa != 0 && wa == rb) begin e.b = wd; e.bb = mb && (ba == rb); end
`endif
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: the DUT outputs are settled by the falling edge of each cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("data_readRegA", data_readRegA, e.a);
      chk("data_readRegB", data_readRegB, e.b);
      chk("busy_A", W'(busy_A), W'(e.ba));
      chk("busy_B", W'(busy_B), W'(e.bb));
      chk("busy_count", W'(busy_count), W'(e.cnt));
    end
  end

  function automatic int rnd_addr();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, N-1));
  endfunction

  initial begin
    ctrl_reset = 1; ctrl_writeEnable = 0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_markBusy = 0; ctrl_busyReg = '0; ctrl_readRegA = '0; ctrl_readRegB = '0;
    model_clear();
    step(0, 0, 0, 0, 0, 5, 7, 1);
    // reset mid-cycle after a write and a mark
    step(1, 5, 32'hDEADBEEF, 1, 7, 5, 7, 0);
    step(0, 0, 0, 0, 0, 5, 7, 0);
    step(0, 0, 0, 0, 0, 5, 7, 1);
    step(0, 0, 0, 0, 0, 5, 7, 0);
    // register 0 and the top register
    step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    step(1, 31, 32'h12345678, 0, 0, 0, 31, 0);
    step(0, 0, 0, 0, 0, 31, 0, 0);
    // scoreboard mark/clear and same-index mark+write
    step(0, 0, 0, 1, 3, 3, 4, 0);
    step(1, 3, 32'hA5, 0, 0, 3, 4, 0);
    step(0, 0, 0, 1, 4, 3, 4, 0);
    step(1, 4, 32'h11, 1, 4, 3, 4, 0);
    step(0, 0, 0, 0, 0, 3, 4, 0);
    // write r9 while reading it on port B
    step(1, 9, 32'hCAFE, 0, 0, 4, 9, 0);
    step(0, 0, 0, 0, 0, 4, 9, 0);
    // fill the scoreboard to its maximum, then drain it
    for (int i = 1; i < N; i++) step(0, 0, 0, 1, i, i, i-1, 0);
    step(0, 0, 0, 0, 0, 1, N-1, 0);
    for (int i = 1; i < N; i++) step(1, i, W'(i * 32'h01010101), 0, 0, i, i-1, 0);
    step(0, 0, 0, 0, 0, 1, N-1, 0);
    // random traffic with occasional mid-cycle resets
    for (int k = 0; k < 600; k++) begin
      bit rst;
      rst = ($urandom_range(0, 60) == 0);
      step(rst ? 1'b0 : 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           rst ? 1'b0 : 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr(), rst);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with one write port, two asynchronous read ports, a hardwired-zero register 0 and a per-register busy scoreboard. It is the successor to the fixed 32×32 write-side block. It sits between decode and writeback in the pipelined processor. Decode reads operands and busy status to decide stalls; writeback commits results and clears busy bits.

## Interface

Parameters:
- `WIDTH`, 32: data width of each register.
- `ADDR_W`, 5: register index width; depth is `2**ADDR_W`.

Ports (all inputs sampled and all state updated on `posedge clock`):
- `clock`, in, 1: sole clock.
- `ctrl_reset`, in, 1: asynchronous, active-high reset. Clears all registers and all busy bits.
- `ctrl_writeEnable`, in, 1: commit `data_writeReg` to `ctrl_writeReg`.
- `ctrl_writeReg`, in, `ADDR_W`: write index.
- `data_writeReg`, in, `WIDTH`: write data.
- `ctrl_markBusy`, in, 1: set the busy bit of `ctrl_busyReg` (an instruction issued with this destination).
- `ctrl_busyReg`, in, `ADDR_W`: index to mark busy.
- `ctrl_readRegA`, in, `ADDR_W`: read index, port A.
- `ctrl_readRegB`, in, `ADDR_W`: read index, port B.
- `data_readRegA`, out, `WIDTH`: port A data.
- `data_readRegB`, out, `WIDTH`: port B data.
- `busy_A`, out, 1: port A register has a pending write.
- `busy_B`, out, 1: port B register has a pending write.
- `busy_count`, out, `ADDR_W`: number of busy registers.

## Operation

- Storage: `2**ADDR_W - 1` registers, indices 1..N-1. Index 0 has no storage.
  - Reads of index 0 return 0.
  - Writes to index 0 are ignored.
  - Marking index 0 busy is ignored; `busy` for index 0 is always 0.
- Write: if `ctrl_writeEnable` and the index is not 0, the register takes `data_writeReg` at the edge, and its busy bit is cleared at the same edge.
- Mark: if `ctrl_markBusy` and the index is not 0, the busy bit is set at the edge.
- Simultaneous mark and write to the same index: the register is written and the busy bit ends set. Mark wins, because a new producer supersedes the old one.
- Simultaneous mark and write to different indices: both take effect independently.
- Write to a register that is not busy is legal: data is committed and the busy bit stays 0.
- Mark of a register already busy: the bit stays 1. There is no nesting counter.
- Reads are combinational from the current register contents, except for the bypass described under Configuration.
- `busy_A` and `busy_B` are combinational from the current busy bits. They do not reflect same-cycle write or mark inputs.
- `busy_count`:
  - Registered population count of the busy bits, updated every edge to match the post-edge bit vector.
  - Maximum value is `2**ADDR_W - 1`, which fits in `ADDR_W` bits.
  - Increments only when the addressed bit actually changes from 0 to 1; decrements only when a bit actually changes from 1 to 0.
  - A same-index mark and write leaves the count unchanged if the bit was 1; if the bit was 0, the count increments.

## Timing

- Write latency: data is visible on an un-bypassed read in the cycle after the edge.
- Busy latency: a mark at edge k gives `busy_*` = 1 from cycle k+1. A write at edge k gives `busy_*` = 0 from cycle k+1, unless the register was also marked at edge k.
- Reset:
  - Asynchronous assertion forces, immediately and without a clock: all registers to 0, all busy bits to 0, `busy_count` to 0.
  - Therefore `data_readRegA` = `data_readRegB` = 0 and `busy_A` = `busy_B` = 0.
  - While reset is held, writes and marks are ignored.
  - The first edge after deassertion performs normal updates.
- Reset mid-operation discards all pending-busy state. No writes are replayed.

## Configuration

- `REGFILE_BYPASS_EN` defined:
  - If `ctrl_writeEnable`, the write index is not 0, and the write index equals a read index, that read port returns `data_writeReg` in the same cycle (write-through forwarding).
  - The corresponding `busy_*` output is also forced to 0 that cycle, unless the register is being marked busy in the same cycle.
- `REGFILE_BYPASS_EN` undefined: reads return the stored value, and `busy_*` reflects the stored busy bit only. The consumer stalls one extra cycle.

## Test plan

- **Reset:** write 0xDEADBEEF to r5, mark r7, then assert `ctrl_reset` between edges → immediately r5 reads 0, `busy_*` = 0, `busy_count` = 0.
- **Register 0:**
  - Write 0xFFFFFFFF to r0 and mark r0 → r0 reads 0, `busy` stays 0, `busy_count` = 0.
  - Write 0x12345678 to r31 → r31 reads 0x12345678 the next cycle.
- **Scoreboard:**
  - Mark r3 → `busy_A` (readRegA = 3) = 1 and `busy_count` = 1 the next cycle.
  - Write r3 = 0xA5 → `busy_A` = 0, `busy_count` = 0, r3 reads 0xA5.
- **Simultaneous same index:** with r4 busy, write r4 = 0x11 and mark r4 at the same edge → r4 reads 0x11, busy stays 1, `busy_count` unchanged.
- **Bypass:** write r9 = 0xCAFE while readRegB = 9 in the same cycle.
  - With `REGFILE_BYPASS_EN`: `data_readRegB` = 0xCAFE that cycle.
  - Without it: the old value that cycle, 0xCAFE the next.
- **Parametrisation:** `WIDTH` = 16, `ADDR_W` = 3; mark r1..r7 → `busy_count` = 7; write all → `busy_count` = 0; each register holds its 16-bit value.
